// File: rtl/dso_trig_pkg.sv
// Shared mode and state encodings for the scope trigger controller.
package dso_trig_pkg;

  localparam logic [1:0] MODE_NORM      = 2'd0;
  localparam logic [1:0] MODE_AUTO      = 2'd1;
  localparam logic [1:0] MODE_IMMEDIATE = 2'd2;
  localparam logic [1:0] MODE_SINGLE    = 2'd3;

  typedef enum logic [2:0] {
    TS_HOLDOFF = 3'd0,
    TS_ARMED   = 3'd1,
    TS_FIRED   = 3'd2,
    TS_DONE    = 3'd3,
    TS_STOPPED = 3'd4
  } ts_e;

endpackage

// File: rtl/trigger_controller_if.sv
// Config, sample stream and adc_driver status/request bundle for trigger_controller.
interface trigger_controller_if #(
  parameter int DATA_W = 8,
  parameter int TMO_W  = 24
);
  logic [1:0]        mode;
  logic              edge_sel;
  logic [DATA_W-1:0] level;
  logic [DATA_W-1:0] hyst;
  logic [TMO_W-1:0]  holdoff;
  logic [TMO_W-1:0]  auto_timeout;
  logic              arm;
  logic              sample_en;
  logic [DATA_W-1:0] adc_data;
  logic              waiting_for_trigger;
  logic              triggered;
  logic              trigger_req;
  logic              forced;
  logic [2:0]        ctl_state;

  // Request/acknowledge: trigger_req is a level that rises once a trigger is
  // decided and stays high until triggered=1 is seen; the controller then
  // waits for triggered to return to 0 before it may request again.
  modport master (
    output mode, edge_sel, level, hyst, holdoff, auto_timeout, arm,
           sample_en, adc_data, waiting_for_trigger, triggered,
    input  trigger_req, forced, ctl_state
  );

  modport slave (
    input  mode, edge_sel, level, hyst, holdoff, auto_timeout, arm,
           sample_en, adc_data, waiting_for_trigger, triggered,
    output trigger_req, forced, ctl_state
  );
endinterface

// File: rtl/trig_edge_qual.sv
// Hysteresis edge detector: a sample must first cross the far threshold
// (qual) before crossing level produces an edge event.
module trig_edge_qual #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              sample_en_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic [DATA_W-1:0] hyst_i,
  input  logic              edge_sel_i,
  output logic              edge_evt_o
);

  logic [DATA_W:0]   lo_w, hi_w;
  logic [DATA_W-1:0] lo_thr, hi_thr;
  logic              set_c, hit_c;
  logic              qual_q, qual_d;

  always_comb begin
    // One extra bit catches borrow/carry so the thresholds clamp instead of wrapping.
    lo_w   = {1'b0, level_i} - {1'b0, hyst_i};
    hi_w   = {1'b0, level_i} + {1'b0, hyst_i};
    lo_thr = lo_w[DATA_W] ? '0 : lo_w[DATA_W-1:0];
    hi_thr = hi_w[DATA_W] ? '1 : hi_w[DATA_W-1:0];
    if (edge_sel_i) begin
      set_c = (adc_data_i >= hi_thr);
      hit_c = (adc_data_i <= level_i);
    end else begin
      set_c = (adc_data_i <= lo_thr);
      hit_c = (adc_data_i >= level_i);
    end
    edge_evt_o = sample_en_i && qual_q && hit_c;
    qual_d     = qual_q;
    if (clr_i || edge_evt_o) begin
      qual_d = 1'b0;
    end else if (sample_en_i && set_c) begin
      qual_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qual_q <= 1'b0;
    end else begin
      qual_q <= qual_d;
    end
  end

endmodule

// File: rtl/trigger_controller.sv
// Trigger decision FSM for adc_driver: holdoff, arming, edge/auto/immediate
// firing and single-shot stop, with a registered trigger_req.
module trigger_controller
  import dso_trig_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TMO_W  = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  trigger_controller_if.slave bus
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

  ts_e              state_q, state_d;
  logic [TMO_W-1:0] hcnt_q, hcnt_d;
  logic [TMO_W-1:0] tcnt_q, tcnt_d;
  logic             trig_q, trig_d;
  logic             forced_q, forced_d;
  logic             qual_clr;
  logic             edge_evt;
  logic             fire_edge, fire_tmo;

  trig_edge_qual #(.DATA_W(DATA_W)) u_qual (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (qual_clr),
    .sample_en_i (bus.sample_en),
    .adc_data_i  (bus.adc_data),
    .level_i     (bus.level),
    .hyst_i      (bus.hyst),
    .edge_sel_i  (bus.edge_sel),
    .edge_evt_o  (edge_evt)
  );

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    tcnt_d    = tcnt_q;
    forced_d  = forced_q;
    qual_clr  = 1'b0;
    fire_edge = edge_evt && (bus.mode != MODE_IMMEDIATE);
    fire_tmo  = (bus.mode == MODE_AUTO) && (tcnt_q == bus.auto_timeout);
    case (state_q)
      TS_HOLDOFF: begin
        if (bus.sample_en && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
        if ((hcnt_q >= bus.holdoff) && bus.waiting_for_trigger) begin
          state_d  = TS_ARMED;
          tcnt_d   = '0;
          qual_clr = 1'b1;
        end
      end
      TS_ARMED: begin
        if (bus.sample_en && (tcnt_q != CNT_MAX)) tcnt_d = tcnt_q + CNT_ONE;
        // A driver that stops waiting aborts the arm rather than receiving a request.
        if (!bus.waiting_for_trigger) begin
          state_d = TS_HOLDOFF;
          hcnt_d  = '0;
        end else if (fire_edge || (bus.mode == MODE_IMMEDIATE)) begin
          state_d  = TS_FIRED;
          forced_d = 1'b0;
        end else if (fire_tmo) begin
          state_d  = TS_FIRED;
          forced_d = 1'b1;
        end
      end
      TS_FIRED: begin
        if (bus.triggered) state_d = TS_DONE;
      end
      TS_DONE: begin
        if (!bus.triggered) begin
          if (bus.mode == MODE_SINGLE) begin
            state_d = TS_STOPPED;
          end else begin
            state_d = TS_HOLDOFF;
            hcnt_d  = '0;
          end
        end
      end
      TS_STOPPED: begin
        if (bus.arm || (bus.mode != MODE_SINGLE)) begin
          state_d = TS_HOLDOFF;
          hcnt_d  = '0;
        end
      end
      default: begin
        state_d = TS_HOLDOFF;
        hcnt_d  = '0;
      end
    endcase
    trig_d = (state_d == TS_FIRED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TS_HOLDOFF;
      hcnt_q   <= '0;
      tcnt_q   <= '0;
      trig_q   <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      tcnt_q   <= tcnt_d;
      trig_q   <= trig_d;
      forced_q <= forced_d;
    end
  end

  assign bus.trigger_req = trig_q;
  assign bus.forced      = forced_q;
  assign bus.ctl_state   = state_q;

endmodule

// File: tb/tb_trigger_controller.sv
// Directed bench for trigger_controller: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_trigger_controller;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  trigger_controller_if #(.DATA_W(8), .TMO_W(24)) bus ();

  trigger_controller #(.DATA_W(8), .TMO_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver tasks: each starts and ends on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] d);
    bus.sample_en = 1'b1;
    bus.adc_data  = d;
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic complete();
    bus.triggered           = 1'b1;
    bus.waiting_for_trigger = 1'b0;
    idle(1);
    bus.triggered = 1'b0;
    idle(1);
  endtask

  task automatic arm_wait();
    bus.waiting_for_trigger = 1'b1;
    idle(1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n                   = 1'b0;
    bus.mode                = 2'd0;
    bus.edge_sel            = 1'b0;
    bus.level               = 8'd128;
    bus.hyst                = 8'd8;
    bus.holdoff             = 24'd0;
    bus.auto_timeout        = 24'd0;
    bus.arm                 = 1'b0;
    bus.sample_en           = 1'b0;
    bus.adc_data            = 8'd0;
    bus.waiting_for_trigger = 1'b0;
    bus.triggered           = 1'b0;
    idle(2);
    check_eq("rst_state", 32'(bus.ctl_state), 32'd0);
    check_eq("rst_req", 32'(bus.trigger_req), 32'd0);
    check_eq("rst_forced", 32'(bus.forced), 32'd0);
    rst_n = 1'b1;
    idle(1);
    check_eq("hold_no_wait", 32'(bus.ctl_state), 32'd0);

    // NORM rising, holdoff 0
    arm_wait();
    check_eq("t1_armed", 32'(bus.ctl_state), 32'd1);
    put(8'd100); put(8'd119); put(8'd125);
    check_eq("t1_pre_req", 32'(bus.trigger_req), 32'd0);
    put(8'd130);
    check_eq("t1_req", 32'(bus.trigger_req), 32'd1);
    check_eq("t1_fired", 32'(bus.ctl_state), 32'd2);
    check_eq("t1_forced", 32'(bus.forced), 32'd0);
    idle(2);
    check_eq("t1_req_held", 32'(bus.trigger_req), 32'd1);
    bus.triggered = 1'b1;
    bus.waiting_for_trigger = 1'b0;
    idle(1);
    check_eq("t1_done", 32'(bus.ctl_state), 32'd3);
    check_eq("t1_req_drop", 32'(bus.trigger_req), 32'd0);
    bus.triggered = 1'b0;
    idle(1);
    check_eq("t1_back_hold", 32'(bus.ctl_state), 32'd0);

    // no dip after arming -> no fire, then dip + edge
    arm_wait();
    put(8'd125); put(8'd130);
    check_eq("t2_no_fire", 32'(bus.trigger_req), 32'd0);
    check_eq("t2_still_armed", 32'(bus.ctl_state), 32'd1);
    put(8'd120);
    check_eq("t2_dip_no_fire", 32'(bus.trigger_req), 32'd0);
    put(8'd128);
    check_eq("t2_fire", 32'(bus.trigger_req), 32'd1);
    complete();

    // AUTO timeout
    bus.mode = 2'd1;
    bus.auto_timeout = 24'd5;
    arm_wait();
    repeat (5) put(8'd50);
    check_eq("t3_pre_tmo", 32'(bus.trigger_req), 32'd0);
    idle(1);
    check_eq("t3_tmo_req", 32'(bus.trigger_req), 32'd1);
    check_eq("t3_tmo_forced", 32'(bus.forced), 32'd1);
    complete();
    // edge on the timeout cycle wins
    arm_wait();
    repeat (5) put(8'd50);
    put(8'd130);
    check_eq("t3_edge_req", 32'(bus.trigger_req), 32'd1);
    check_eq("t3_edge_forced", 32'(bus.forced), 32'd0);
    complete();

    // IMMEDIATE
    bus.mode = 2'd2;
    arm_wait();
    check_eq("imm_armed", 32'(bus.ctl_state), 32'd1);
    idle(1);
    check_eq("imm_fired", 32'(bus.ctl_state), 32'd2);
    complete();

    // SINGLE
    bus.mode = 2'd3;
    arm_wait();
    put(8'd100); put(8'd130);
    check_eq("t4_req", 32'(bus.trigger_req), 32'd1);
    bus.triggered = 1'b1;
    bus.waiting_for_trigger = 1'b0;
    idle(1);
    bus.triggered = 1'b0;
    idle(1);
    check_eq("t4_stopped", 32'(bus.ctl_state), 32'd4);
    bus.waiting_for_trigger = 1'b1;
    put(8'd100); put(8'd130);
    idle(2);
    check_eq("t4_stay_stopped", 32'(bus.ctl_state), 32'd4);
    check_eq("t4_no_req", 32'(bus.trigger_req), 32'd0);
    bus.arm = 1'b1;
    idle(1);
    bus.arm = 1'b0;
    check_eq("t4_arm_hold", 32'(bus.ctl_state), 32'd0);
    idle(1);
    check_eq("t4_rearmed", 32'(bus.ctl_state), 32'd1);
    bus.waiting_for_trigger = 1'b0;
    idle(1);
    check_eq("t4_wait_drop", 32'(bus.ctl_state), 32'd0);

    // holdoff 10
    bus.mode = 2'd0;
    bus.holdoff = 24'd10;
    bus.waiting_for_trigger = 1'b1;
    repeat (4) put(8'd100);
    put(8'd130);
    check_eq("t5_ho_ignore_req", 32'(bus.trigger_req), 32'd0);
    check_eq("t5_ho_ignore_st", 32'(bus.ctl_state), 32'd0);
    repeat (5) put(8'd100);
    check_eq("t5_ho_still", 32'(bus.ctl_state), 32'd0);
    idle(1);
    check_eq("t5_ho_armed", 32'(bus.ctl_state), 32'd1);
    put(8'd100); put(8'd130);
    check_eq("t5_ho_fire", 32'(bus.trigger_req), 32'd1);
    complete();

    // falling, hi_thr clamps to 255
    bus.holdoff  = 24'd0;
    bus.edge_sel = 1'b1;
    bus.level    = 8'd250;
    bus.hyst     = 8'd10;
    arm_wait();
    put(8'd254); put(8'd240);
    check_eq("fall_no_fire", 32'(bus.trigger_req), 32'd0);
    put(8'd255); put(8'd250);
    check_eq("fall_fire", 32'(bus.trigger_req), 32'd1);
    complete();

    // rising, lo_thr clamps to 0
    bus.edge_sel = 1'b0;
    bus.level    = 8'd5;
    bus.hyst     = 8'd10;
    arm_wait();
    put(8'd3); put(8'd8);
    check_eq("floor_no_fire", 32'(bus.trigger_req), 32'd0);
    put(8'd0); put(8'd5);
    check_eq("floor_fire", 32'(bus.trigger_req), 32'd1);
    complete();

    // async reset while FIRED
    bus.mode = 2'd1;
    bus.auto_timeout = 24'd2;
    bus.level = 8'd128;
    bus.hyst  = 8'd8;
    arm_wait();
    put(8'd50); put(8'd50);
    idle(1);
    check_eq("t6_fired", 32'(bus.ctl_state), 32'd2);
    check_eq("t6_forced", 32'(bus.forced), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_async_req", 32'(bus.trigger_req), 32'd0);
    check_eq("t6_async_state", 32'(bus.ctl_state), 32'd0);
    bus.waiting_for_trigger = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    check_eq("t6_post_state", 32'(bus.ctl_state), 32'd0);
    check_eq("t6_post_forced", 32'(bus.forced), 32'd0);
    check_eq("t6_post_req", 32'(bus.trigger_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
